// File: rtl/difftest_arch_state_probe_pkg.sv
// Shared constants for the differential-test architectural-state probe:
// word sizes, CSR slot order and read-index map.
package difftest_arch_state_probe_pkg;

  localparam int XLEN = 64;
  localparam int NCSR = 18;

  localparam int CSR_PRIV     = 0;
  localparam int CSR_MSTATUS  = 1;
  localparam int CSR_SSTATUS  = 2;
  localparam int CSR_MEPC     = 3;
  localparam int CSR_SEPC     = 4;
  localparam int CSR_MTVAL    = 5;
  localparam int CSR_STVAL    = 6;
  localparam int CSR_MTVEC    = 7;
  localparam int CSR_STVEC    = 8;
  localparam int CSR_MCAUSE   = 9;
  localparam int CSR_SCAUSE   = 10;
  localparam int CSR_SATP     = 11;
  localparam int CSR_MIP      = 12;
  localparam int CSR_MIE      = 13;
  localparam int CSR_MSCRATCH = 14;
  localparam int CSR_SSCRATCH = 15;
  localparam int CSR_MIDELEG  = 16;
  localparam int CSR_MEDELEG  = 17;

  localparam int IDX_GPR = 0;
  localparam int IDX_FPR = 32;
  localparam int IDX_CSR = 64;

  localparam int PRIV_MODE_M = 3;

endpackage

// File: rtl/difftest_arch_state_probe_arch_reg_bank.sv
// N-word snapshot bank: loads every word on capture, holds otherwise, and
// flags the words whose captured value differs from the previous snapshot.
module arch_reg_bank
  import difftest_arch_state_probe_pkg::*;
#(
  parameter int N         = 32,
  parameter bit ZERO_IDX0 = 1'b0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic [N*XLEN-1:0] d_flat,
  output logic [N*XLEN-1:0] q_flat,
  output logic [N-1:0]      changed
);

  logic [XLEN-1:0] nxt   [N];
  logic [XLEN-1:0] q_r   [N];
  logic [N-1:0]    chg_r;

  // Word 0 of a zero-pinned bank (x0) loads 0, so its snapshot never moves
  // and its change flag can never rise.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      nxt[i] = d_flat[i*XLEN +: XLEN];
    end
    if (ZERO_IDX0) begin
      nxt[0] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        q_r[i] <= '0;
      end
      chg_r <= '0;
    end else if (capture_en) begin
      for (int i = 0; i < N; i++) begin
        q_r[i]   <= nxt[i];
        chg_r[i] <= (nxt[i] != q_r[i]);
      end
    end else begin
      chg_r <= '0;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      q_flat[i*XLEN +: XLEN] = q_r[i];
    end
  end

  assign changed = chg_r;

endmodule

// File: rtl/difftest_arch_state_probe.sv
// Passive probe beside the core: registers GPR/FPR/CSR state each capture,
// reports per-word changes and offers an indexed combinational read port.
module difftest_arch_state_probe
  import difftest_arch_state_probe_pkg::*;
(
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [7:0]           coreid,
  input  logic                 capture_en,
  input  logic [32*XLEN-1:0]   gpr_flat,
  input  logic [32*XLEN-1:0]   fpr_flat,
  input  logic [NCSR*XLEN-1:0] csr_flat,
  output logic                 snap_valid,
  output logic [7:0]           snap_coreid,
  output logic [32*XLEN-1:0]   snap_gpr_flat,
  output logic [32*XLEN-1:0]   snap_fpr_flat,
  output logic [NCSR*XLEN-1:0] snap_csr_flat,
  output logic [31:0]          gpr_changed,
  output logic [31:0]          fpr_changed,
  output logic [NCSR-1:0]      csr_changed,
  input  logic [6:0]           rd_idx,
  output logic [XLEN-1:0]      rd_data
);

  logic [6:0] csr_sel;

  arch_reg_bank #(.N(32), .ZERO_IDX0(1'b1)) u_gpr_bank (
    .clock      (clock),
    .rst_n      (rst_n),
    .capture_en (capture_en),
    .d_flat     (gpr_flat),
    .q_flat     (snap_gpr_flat),
    .changed    (gpr_changed)
  );

  arch_reg_bank #(.N(32), .ZERO_IDX0(1'b0)) u_fpr_bank (
    .clock      (clock),
    .rst_n      (rst_n),
    .capture_en (capture_en),
    .d_flat     (fpr_flat),
    .q_flat     (snap_fpr_flat),
    .changed    (fpr_changed)
  );

  arch_reg_bank #(.N(NCSR), .ZERO_IDX0(1'b0)) u_csr_bank (
    .clock      (clock),
    .rst_n      (rst_n),
    .capture_en (capture_en),
    .d_flat     (csr_flat),
    .q_flat     (snap_csr_flat),
    .changed    (csr_changed)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      snap_valid  <= 1'b0;
      snap_coreid <= '0;
    end else if (capture_en) begin
      snap_valid  <= 1'b1;
      snap_coreid <= coreid;
    end
  end

  assign csr_sel = rd_idx - 7'(IDX_CSR);

  // GPR and FPR ranges are both 32-aligned, so the low five index bits
  // select the word directly.
  always_comb begin
    rd_data = '0;
    if (rd_idx < 7'(IDX_FPR)) begin
      rd_data = snap_gpr_flat[int'(rd_idx[4:0])*XLEN +: XLEN];
    end else if (rd_idx < 7'(IDX_CSR)) begin
      rd_data = snap_fpr_flat[int'(rd_idx[4:0])*XLEN +: XLEN];
    end else if (rd_idx < 7'(IDX_CSR + NCSR)) begin
      rd_data = snap_csr_flat[int'(csr_sel)*XLEN +: XLEN];
    end
  end

endmodule

// File: tb/tb_difftest_arch_state_probe.sv
// Directed bench for difftest_arch_state_probe: a reference model pushes
// expected snapshot state to a queue each cycle; results are popped and checked.
module tb_difftest_arch_state_probe;
  import difftest_arch_state_probe_pkg::*;

  typedef logic [2047:0] wide_t;

  localparam int K_VALID = 0;
  localparam int K_CORE  = 1;
  localparam int K_GPRF  = 2;
  localparam int K_FPRF  = 3;
  localparam int K_CSRF  = 4;
  localparam int K_GCHG  = 5;
  localparam int K_FCHG  = 6;
  localparam int K_CCHG  = 7;
  localparam int K_GW    = 8;
  localparam int K_FW    = 9;
  localparam int K_CW    = 10;
  localparam int K_RD    = 11;

  typedef struct {
    string tag;
    int    kind;
    int    idx;
    wide_t exp;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 rst_n;
  logic [7:0]           coreid;
  logic                 capture_en;
  logic [32*XLEN-1:0]   gpr_flat;
  logic [32*XLEN-1:0]   fpr_flat;
  logic [NCSR*XLEN-1:0] csr_flat;
  logic                 snap_valid;
  logic [7:0]           snap_coreid;
  logic [32*XLEN-1:0]   snap_gpr_flat;
  logic [32*XLEN-1:0]   snap_fpr_flat;
  logic [NCSR*XLEN-1:0] snap_csr_flat;
  logic [31:0]          gpr_changed;
  logic [31:0]          fpr_changed;
  logic [NCSR-1:0]      csr_changed;
  logic [6:0]           rd_idx;
  logic [XLEN-1:0]      rd_data;

  // reference model state
  logic                 m_valid;
  logic [7:0]           m_core;
  logic [32*XLEN-1:0]   m_gpr;
  logic [32*XLEN-1:0]   m_fpr;
  logic [NCSR*XLEN-1:0] m_csr;
  logic [31:0]          m_gchg;
  logic [31:0]          m_fchg;
  logic [NCSR-1:0]      m_cchg;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  difftest_arch_state_probe dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .coreid        (coreid),
    .capture_en    (capture_en),
    .gpr_flat      (gpr_flat),
    .fpr_flat      (fpr_flat),
    .csr_flat      (csr_flat),
    .snap_valid    (snap_valid),
    .snap_coreid   (snap_coreid),
    .snap_gpr_flat (snap_gpr_flat),
    .snap_fpr_flat (snap_fpr_flat),
    .snap_csr_flat (snap_csr_flat),
    .gpr_changed   (gpr_changed),
    .fpr_changed   (fpr_changed),
    .csr_changed   (csr_changed),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic wide_t observe(int kind, int idx);
    wide_t v;
    v = '0;
    case (kind)
      K_VALID: v = wide_t'(snap_valid);
      K_CORE:  v = wide_t'(snap_coreid);
      K_GPRF:  v = wide_t'(snap_gpr_flat);
      K_FPRF:  v = wide_t'(snap_fpr_flat);
      K_CSRF:  v = wide_t'(snap_csr_flat);
      K_GCHG:  v = wide_t'(gpr_changed);
      K_FCHG:  v = wide_t'(fpr_changed);
      K_CCHG:  v = wide_t'(csr_changed);
      K_GW:    v = wide_t'(snap_gpr_flat[idx*XLEN +: XLEN]);
      K_FW:    v = wide_t'(snap_fpr_flat[idx*XLEN +: XLEN]);
      K_CW:    v = wide_t'(snap_csr_flat[idx*XLEN +: XLEN]);
      K_RD:    v = wide_t'(rd_data);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic int first_diff(wide_t a, wide_t b);
    for (int w = 0; w < 32; w++) begin
      if (a[w*64 +: 64] !== b[w*64 +: 64]) return w;
    end
    return 0;
  endfunction

  function automatic logic [XLEN-1:0] model_rd(int idx);
    if (idx < IDX_FPR) return m_gpr[idx*XLEN +: XLEN];
    if (idx < IDX_CSR) return m_fpr[(idx-IDX_FPR)*XLEN +: XLEN];
    if (idx < IDX_CSR + NCSR) return m_csr[(idx-IDX_CSR)*XLEN +: XLEN];
    return '0;
  endfunction

  task automatic expect_val(string tag, int kind, int idx, wide_t exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t  e;
    wide_t obs;
    int    w;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.kind == K_RD) begin
        rd_idx = 7'(e.idx);
        #1;
      end
      obs = observe(e.kind, e.idx);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        w = first_diff(obs, e.exp);
        $error("FAIL %s idx=%0d word%0d: observed %h expected %h", e.tag, e.idx, w,
               obs[w*64 +: 64], e.exp[w*64 +: 64]);
      end
    end
  endtask

  // Model the edge from current inputs, queue full-state expectations,
  // then clock and compare (plus any directed items queued by the caller).
  task automatic step();
    logic [XLEN-1:0] nv;
    if (!rst_n) begin
      m_valid = 1'b0; m_core = '0;
      m_gpr = '0; m_fpr = '0; m_csr = '0;
      m_gchg = '0; m_fchg = '0; m_cchg = '0;
    end else if (capture_en) begin
      for (int i = 0; i < 32; i++) begin
        nv = (i == 0) ? '0 : gpr_flat[i*XLEN +: XLEN];
        m_gchg[i] = (nv != m_gpr[i*XLEN +: XLEN]);
        m_gpr[i*XLEN +: XLEN] = nv;
        nv = fpr_flat[i*XLEN +: XLEN];
        m_fchg[i] = (nv != m_fpr[i*XLEN +: XLEN]);
        m_fpr[i*XLEN +: XLEN] = nv;
      end
      for (int i = 0; i < NCSR; i++) begin
        nv = csr_flat[i*XLEN +: XLEN];
        m_cchg[i] = (nv != m_csr[i*XLEN +: XLEN]);
        m_csr[i*XLEN +: XLEN] = nv;
      end
      m_valid = 1'b1;
      m_core  = coreid;
    end else begin
      m_gchg = '0; m_fchg = '0; m_cchg = '0;
    end
    expect_val("snap_valid",  K_VALID, 0, wide_t'(m_valid));
    expect_val("snap_coreid", K_CORE,  0, wide_t'(m_core));
    expect_val("snap_gpr",    K_GPRF,  0, wide_t'(m_gpr));
    expect_val("snap_fpr",    K_FPRF,  0, wide_t'(m_fpr));
    expect_val("snap_csr",    K_CSRF,  0, wide_t'(m_csr));
    expect_val("gpr_changed", K_GCHG,  0, wide_t'(m_gchg));
    expect_val("fpr_changed", K_FCHG,  0, wide_t'(m_fchg));
    expect_val("csr_changed", K_CCHG,  0, wide_t'(m_cchg));
    @(posedge clock);
    #1;
    drain();
  endtask

  task automatic load_pattern(logic [7:0] cid);
    coreid = cid;
    for (int i = 0; i < 32; i++) begin
      gpr_flat[i*XLEN +: XLEN] = 64'(i) * 64'h1111;
      fpr_flat[i*XLEN +: XLEN] = 64'h4000_0000_0000_0000 + 64'(i) * 64'h10;
    end
    for (int i = 0; i < NCSR; i++) begin
      csr_flat[i*XLEN +: XLEN] = 64'h8000_0000 + 64'(i) * 64'h100;
    end
    csr_flat[CSR_PRIV*XLEN +: XLEN]    = 64'(PRIV_MODE_M);
    csr_flat[CSR_MSTATUS*XLEN +: XLEN] = 64'hA_0000_1800;
  endtask

  initial begin
    rst_n = 1'b0; capture_en = 1'b0; coreid = '0; rd_idx = '0;
    gpr_flat = '0; fpr_flat = '0; csr_flat = '0;

    // reset state
    step();
    expect_val("reset_rd0", K_RD, 0, '0);
    drain();

    // 1: first capture after release
    load_pattern(8'h5A);
    rst_n = 1'b1; capture_en = 1'b1;
    expect_val("t1_gpr5", K_GW, 5, wide_t'(64'h5555));
    expect_val("t1_valid", K_VALID, 0, wide_t'(1'b1));
    expect_val("t1_gchg", K_GCHG, 0, wide_t'(32'hFFFF_FFFE));
    expect_val("t1_mstatus_rd", K_RD, 65, wide_t'(64'hA_0000_1800));
    step();
    checks++;
    assert (csr_changed[CSR_MSTATUS] === 1'b1) else begin
      errors++;
      $error("FAIL t1_mstatus_chg: observed %b expected 1", csr_changed[CSR_MSTATUS]);
    end

    // 2: x0 stays zero
    gpr_flat[63:0] = 64'hDEAD_BEEF;
    expect_val("t2_gpr0", K_GW, 0, '0);
    expect_val("t2_gchg", K_GCHG, 0, '0);
    expect_val("t2_rd0", K_RD, 0, '0);
    step();

    // 3: identical recapture, then one FPR change
    expect_val("t3_gchg", K_GCHG, 0, '0);
    expect_val("t3_fchg", K_FCHG, 0, '0);
    expect_val("t3_cchg", K_CCHG, 0, '0);
    step();
    fpr_flat[7*XLEN +: XLEN] = 64'h3FF0_0000_0000_0000;
    expect_val("t3_fchg7", K_FCHG, 0, wide_t'(32'h80));
    expect_val("t3_fpr7", K_FW, 7, wide_t'(64'h3FF0_0000_0000_0000));
    step();

    // 4: hold while inputs toggle
    capture_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      gpr_flat[3*XLEN +: XLEN]        = {$urandom, $urandom};
      fpr_flat[2*XLEN +: XLEN]        = {$urandom, $urandom};
      csr_flat[CSR_MTVAL*XLEN +: XLEN] = {$urandom, $urandom};
      coreid = 8'(c + 1);
      expect_val("t4_hold_gpr3", K_GW, 3, wide_t'(64'h3333));
      expect_val("t4_hold_gchg", K_GCHG, 0, '0);
      step();
    end
    gpr_flat[3*XLEN +: XLEN] = 64'hCAFE_F00D_1234_5678;
    capture_en = 1'b1;
    expect_val("t4_new_gpr3", K_GW, 3, wide_t'(64'hCAFE_F00D_1234_5678));
    expect_val("t4_new_core", K_CORE, 0, wide_t'(8'h03));
    step();

    // 5: reset wins over capture
    rst_n = 1'b0;
    expect_val("t5_valid", K_VALID, 0, '0);
    expect_val("t5_gpr", K_GPRF, 0, '0);
    expect_val("t5_cchg", K_CCHG, 0, '0);
    step();

    // 6: known capture, hold, then sweep rd_idx
    rst_n = 1'b1;
    load_pattern(8'hC3);
    step();
    capture_en = 1'b0;
    step();
    expect_val("t6_priv", K_RD, 64, wide_t'(64'(PRIV_MODE_M)));
    expect_val("t6_rd31", K_RD, 31, wide_t'(64'(31) * 64'h1111));
    for (int i = 0; i < 128; i++) begin
      expect_val("t6_sweep", K_RD, i, wide_t'(model_rd(i)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
